amstrad_mem_arbiter: RTL and testbench

- Shares the single 16-bit system memory port between three requesters: gate-array video fetch, Z80 CPU memory cycles, and the ROM/disk loader.
- Sits between the motherboard (vram_addr/vram_din, mem_addr/mem_rd/mem_wr/cpu_dout/cpu_din) and the SDRAM controller.
- Priority order is video > CPU > loader, with an anti-starvation promotion for the loader.

---
 rtl/amstrad_mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_amstrad_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/amstrad_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | amstrad_mem_arbiter: shares one 16-bit memory port between video fetch,    |
// | Z80 CPU cycles and the ROM/disk loader (video > CPU > loader, anti-starve). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module amstrad_mem_arbiter #(
   parameter int AW         = 23,
   parameter int STARVE_MAX = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          vid_req,
   input  logic [14:0]   vid_addr,
   output logic [15:0]   vid_dout,
   output logic          vid_valid,
   output logic          vid_overrun,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_din,
   output logic [7:0]    cpu_dout,
   output logic          cpu_ack,
   input  logic          ld_wr,
   input  logic [AW-1:0] ld_addr,
   input  logic [7:0]    ld_data,
   output logic          ld_busy,
   output logic          ld_ovf,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-2:0] mem_addr,
   output logic [1:0]    mem_be,
   output logic [15:0]   mem_wdata,
   input  logic [15:0]   mem_rdata,
   input  logic          mem_ack
);

   localparam int              c_SW         = $clog2(STARVE_MAX + 1);
   localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);

   typedef enum logic [1:0] {S_IDLE, S_VID, S_CPU, S_LD} state_t;

   state_t           r_state, w_state_n;
   logic             r_vid_pend, r_cpu_pend, r_cpu_done, r_ld_busy, r_ld_ovf;
   logic [14:0]      r_vid_addr;
   logic [AW-1:0]    r_ld_addr;
   logic [7:0]       r_ld_data;
   logic [c_SW-1:0]  r_starve;
   logic             r_mem_we, w_mem_we_n;
   logic [AW-2:0]    r_mem_addr, w_mem_addr_n;
   logic [1:0]       r_mem_be, w_mem_be_n;
   logic [15:0]      r_mem_wdata, w_mem_wdata_n;
   logic [15:0]      r_vid_dout;
   logic             r_vid_valid, r_vid_overrun, r_cpu_ack;
   logic [7:0]       r_cpu_dout;
   logic             w_take_ld, w_vid_accept, w_cpu_live;
   logic             w_vid_done, w_cpu_fin, w_ld_done, w_ld_grant;

   assign w_vid_done   = (r_state == S_VID) & mem_ack;
   assign w_cpu_fin    = (r_state == S_CPU) & mem_ack;
   assign w_ld_done    = (r_state == S_LD)  & mem_ack;
   assign w_ld_grant   = (r_state == S_IDLE) & (w_state_n == S_LD);
   assign w_vid_accept = vid_req & ((~r_vid_pend & (r_state != S_VID)) | w_vid_done);
   assign w_cpu_live   = (cpu_rd | cpu_wr) & ~r_cpu_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_n;
   end

   always_comb begin
      w_state_n     = r_state;
      w_mem_we_n    = r_mem_we;
      w_mem_addr_n  = r_mem_addr;
      w_mem_be_n    = r_mem_be;
      w_mem_wdata_n = r_mem_wdata;
      w_take_ld     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_vid_pend) begin
               w_state_n     = S_VID;
               w_mem_we_n    = 1'b0;
               w_mem_addr_n  = {{(AW-16){1'b0}}, r_vid_addr};
               w_mem_be_n    = 2'b11;
               w_mem_wdata_n = 16'h0000;
            end else if (r_ld_busy && (r_starve == c_STARVE_MAX)) begin
               w_take_ld = 1'b1;
            end else if (r_cpu_pend) begin
               // simultaneous rd/wr resolves to a write
               w_state_n     = S_CPU;
               w_mem_we_n    = cpu_wr;
               w_mem_addr_n  = cpu_addr[AW-1:1];
               w_mem_be_n    = cpu_addr[0] ? 2'b10 : 2'b01;
               w_mem_wdata_n = {cpu_din, cpu_din};
            end else if (r_ld_busy) begin
               w_take_ld = 1'b1;
            end
            if (w_take_ld) begin
               w_state_n     = S_LD;
               w_mem_we_n    = 1'b1;
               w_mem_addr_n  = r_ld_addr[AW-1:1];
               w_mem_be_n    = r_ld_addr[0] ? 2'b10 : 2'b01;
               w_mem_wdata_n = {r_ld_data, r_ld_data};
            end
         end
         default: begin
            if (mem_ack) w_state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= 2'b00;
         r_mem_wdata <= 16'h0000;
      end else begin
         r_mem_we    <= w_mem_we_n;
         r_mem_addr  <= w_mem_addr_n;
         r_mem_be    <= w_mem_be_n;
         r_mem_wdata <= w_mem_wdata_n;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vid_pend    <= 1'b0;
         r_vid_addr    <= 15'h0000;
         r_vid_overrun <= 1'b0;
      end else begin
         r_vid_overrun <= vid_req & ~w_vid_accept;
         if (w_vid_accept) begin
            r_vid_pend <= 1'b1;
            r_vid_addr <= vid_addr;
         end else if ((r_state == S_IDLE) && (w_state_n == S_VID)) begin
            r_vid_pend <= 1'b0;
         end
      end
   end

   // CPU request is registered so it lines up with vid_pend; a completing
   // access clears it so the still-held strobe is not served twice.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cpu_pend <= 1'b0;
         r_cpu_done <= 1'b0;
      end else begin
         r_cpu_pend <= w_cpu_live & ~w_cpu_fin;
         if (w_cpu_fin)             r_cpu_done <= 1'b1;
         else if (~cpu_rd & ~cpu_wr) r_cpu_done <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ld_busy <= 1'b0;
         r_ld_ovf  <= 1'b0;
         r_ld_addr <= '0;
         r_ld_data <= 8'h00;
         r_starve  <= '0;
      end else begin
         if (w_ld_done) r_ld_busy <= 1'b0;
         if (ld_wr) begin
            if (r_ld_busy) begin
               r_ld_ovf <= 1'b1;
            end else begin
               r_ld_busy <= 1'b1;
               r_ld_addr <= ld_addr;
               r_ld_data <= ld_data;
            end
         end
         if (w_ld_grant)
            r_starve <= '0;
         else if (r_ld_busy && (r_state != S_LD) && (r_starve != c_STARVE_MAX))
            r_starve <= r_starve + c_SW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vid_valid <= 1'b0;
         r_vid_dout  <= 16'h0000;
         r_cpu_ack   <= 1'b0;
         r_cpu_dout  <= 8'h00;
      end else begin
         r_vid_valid <= w_vid_done;
         r_cpu_ack   <= w_cpu_fin;
         if (w_vid_done) r_vid_dout <= mem_rdata;
         // upper byte enable marks an odd CPU byte address
         if (w_cpu_fin && !r_mem_we)
            r_cpu_dout <= r_mem_be[1] ? mem_rdata[15:8] : mem_rdata[7:0];
      end
   end

   assign mem_req     = (r_state != S_IDLE);
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_be      = r_mem_be;
   assign mem_wdata   = r_mem_wdata;
   assign vid_dout    = r_vid_dout;
   assign vid_valid   = r_vid_valid;
   assign vid_overrun = r_vid_overrun;
   assign cpu_dout    = r_cpu_dout;
   assign cpu_ack     = r_cpu_ack;
   assign ld_busy     = r_ld_busy;
   assign ld_ovf      = r_ld_ovf;

endmodule
`default_nettype wire

// File: tb/tb_amstrad_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_amstrad_mem_arbiter: scoreboard bench with a latency-programmable        |
// | backend model. Revision: 1.0                                               |
// +----------------------------------------------------------------------------+
module tb_amstrad_mem_arbiter;

   localparam int AW         = 23;
   localparam int STARVE_MAX = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          vid_req;
   logic [14:0]   vid_addr;
   logic [15:0]   vid_dout;
   logic          vid_valid, vid_overrun;
   logic          cpu_rd, cpu_wr;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_din, cpu_dout;
   logic          cpu_ack;
   logic          ld_wr;
   logic [AW-1:0] ld_addr;
   logic [7:0]    ld_data;
   logic          ld_busy, ld_ovf;
   logic          mem_req, mem_we;
   logic [AW-2:0] mem_addr;
   logic [1:0]    mem_be;
   logic [15:0]   mem_wdata;
   logic [15:0]   mem_rdata = 16'h0000;
   logic          mem_ack   = 1'b0;

   int passed = 0, failed = 0, total = 0;
   int lat = 0, wcnt = 0;
   int ack_cnt = 0, mem_cnt = 0, ovr_cnt = 0;
   int ack0, mem0, ovr0;

   logic [40:0] exp_mem [$];
   logic [15:0] exp_vid [$];
   logic [8:0]  exp_cpu [$];
   logic [15:0] model [int];

   amstrad_mem_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout),
      .vid_valid(vid_valid), .vid_overrun(vid_overrun),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
      .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_busy(ld_busy), .ld_ovf(ld_ovf),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cpu_ack(input string tag);
      for (int i = 0; i < 30 && !cpu_ack; i++) tick();
      chk(tag, cpu_ack, 1'b1);
   endtask

   // Backend: acks after mem_req has been seen for lat+1 sampling points.
   always @(posedge clk) begin
      logic [15:0] w;
      #2;
      mem_ack = 1'b0;
      if (mem_req && !reset) begin
         if (wcnt >= lat) begin
            mem_ack = 1'b1;
            wcnt    = 0;
            w = model.exists(int'(mem_addr)) ? model[int'(mem_addr)] : 16'h0000;
            if (mem_we) begin
               if (mem_be[0]) w[7:0]  = mem_wdata[7:0];
               if (mem_be[1]) w[15:8] = mem_wdata[15:8];
               model[int'(mem_addr)] = w;
            end else begin
               mem_rdata = w;
            end
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   // Scoreboard consumers
   always @(negedge clk) begin
      logic [8:0] c;
      if (mem_req && mem_ack) begin
         mem_cnt++;
         if (exp_mem.size() == 0) chk("mem_unexpected", exp_mem.size(), 1);
         else chk("mem_txn", {mem_we, mem_addr, mem_be, (mem_we ? mem_wdata : 16'h0)},
                  exp_mem.pop_front());
      end
      if (vid_valid) begin
         if (exp_vid.size() == 0) chk("vid_unexpected", exp_vid.size(), 1);
         else chk("vid_dout", vid_dout, exp_vid.pop_front());
      end
      if (cpu_ack) begin
         ack_cnt++;
         if (exp_cpu.size() == 0) chk("cpu_unexpected", exp_cpu.size(), 1);
         else begin
            c = exp_cpu.pop_front();
            if (c[8]) chk("cpu_dout", cpu_dout, c[7:0]);
         end
      end
      if (vid_overrun) ovr_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; vid_req = 1'b0; vid_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
      cpu_addr = '0; cpu_din = '0; ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
      repeat (3) tick();
      chk("rst_outs_a", {vid_dout, vid_valid, vid_overrun, cpu_dout, cpu_ack,
                         ld_busy, ld_ovf, mem_req, mem_we}, 0);
      chk("rst_outs_b", {mem_addr, mem_be, mem_wdata}, 0);
      reset = 1'b0;
      tick();

      // Video latency with a zero-wait backend
      model[32'h1234] = 16'hBEEF;
      vid_addr = 15'h1234; vid_req = 1'b1;
      exp_mem.push_back({1'b0, 22'h001234, 2'b11, 16'h0});
      exp_vid.push_back(16'hBEEF);
      tick();
      vid_req = 1'b0;
      chk("vid_k1_no_req", mem_req, 0);
      tick();
      chk("vid_k2_req", {mem_req, mem_we, mem_be}, {1'b1, 1'b0, 2'b11});
      chk("vid_k2_addr", mem_addr, 22'h001234);
      tick();
      chk("vid_k3_valid", {vid_valid, vid_dout}, {1'b1, 16'hBEEF});
      tick();
      chk("vid_valid_pulse", vid_valid, 0);

      // Held CPU write served once
      ack0 = ack_cnt; mem0 = mem_cnt;
      cpu_wr = 1'b1; cpu_addr = 23'h00C001; cpu_din = 8'h5A;
      exp_mem.push_back({1'b1, 22'h006000, 2'b10, 16'h5A5A});
      exp_cpu.push_back(9'h000);
      repeat (10) tick();
      cpu_wr = 1'b0;
      tick();
      chk("cpu_wr_acks", ack_cnt - ack0, 1);
      chk("cpu_wr_txns", mem_cnt - mem0, 1);

      // Video and CPU read together: video first
      model[32'h40] = 16'h7777;
      model[32'h80] = 16'h12AB;
      vid_addr = 15'h0040; vid_req = 1'b1;
      cpu_rd = 1'b1; cpu_addr = 23'h000100;
      exp_mem.push_back({1'b0, 22'h000040, 2'b11, 16'h0});
      exp_mem.push_back({1'b0, 22'h000080, 2'b01, 16'h0});
      exp_vid.push_back(16'h7777);
      exp_cpu.push_back({1'b1, 8'hAB});
      tick();
      vid_req = 1'b0;
      wait_cpu_ack("vid_cpu_ack");
      chk("vid_cpu_byte", cpu_dout, 8'hAB);
      cpu_rd = 1'b0;
      tick();

      // Loader against a re-strobing CPU with a slow backend
      lat = 3;
      model[32'h100] = 16'hC3D4;
      cpu_addr = 23'h000201; ld_addr = 23'h000300; ld_data = 8'h99;
      exp_mem.push_back({1'b0, 22'h000100, 2'b10, 16'h0});
      exp_mem.push_back({1'b1, 22'h000180, 2'b01, 16'h9999});
      exp_cpu.push_back({1'b1, 8'hC3});
      cpu_rd = 1'b1; ld_wr = 1'b1;
      tick();
      ld_wr = 1'b0;
      chk("ld_busy_set", ld_busy, 1);
      for (int n = 0; n < STARVE_MAX + 8 && ld_busy; n++) begin
         if (cpu_ack) cpu_rd = 1'b0;
         else if (!cpu_rd) begin
            cpu_rd = 1'b1;
            exp_mem.push_back({1'b0, 22'h000100, 2'b10, 16'h0});
            exp_cpu.push_back({1'b1, 8'hC3});
         end
         tick();
      end
      chk("ld_served_in_bound", ld_busy, 0);
      if (cpu_rd) wait_cpu_ack("starve_cpu_drain");
      cpu_rd = 1'b0;
      repeat (2) tick();

      // Video overrun and loader overflow
      lat = 0; ovr0 = ovr_cnt;
      model[32'h55] = 16'hA5C3;
      exp_mem.push_back({1'b0, 22'h000055, 2'b11, 16'h0});
      exp_mem.push_back({1'b1, 22'h000200, 2'b10, 16'h1111});
      exp_vid.push_back(16'hA5C3);
      vid_addr = 15'h0055; vid_req = 1'b1;
      ld_addr = 23'h000401; ld_data = 8'h11; ld_wr = 1'b1;
      tick();
      vid_addr = 15'h0066; ld_data = 8'h22;
      tick();
      vid_req = 1'b0; ld_data = 8'h33;
      tick();
      ld_wr = 1'b0;
      chk("ld_ovf_set", ld_ovf, 1);
      repeat (8) tick();
      chk("vid_overrun_count", ovr_cnt - ovr0, 1);
      chk("ld_ovf_sticky", {ld_ovf, ld_busy}, 2'b10);

      // Reset in the middle of a CPU access
      lat = 6; ack0 = ack_cnt;
      cpu_wr = 1'b1; cpu_addr = 23'h000010; cpu_din = 8'h77;
      for (int i = 0; i < 10 && !mem_req; i++) tick();
      chk("rst_req_up", mem_req, 1);
      #2 reset = 1'b1;
      #1 chk("rst_async_drop", mem_req, 0);
      cpu_wr = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (4) tick();
      chk("rst_idle_after", {mem_req, ld_ovf, ld_busy}, 0);
      chk("rst_no_ack", ack_cnt - ack0, 0);

      lat = 0;
      exp_mem.push_back({1'b1, 22'h000008, 2'b01, 16'h7777});
      exp_cpu.push_back(9'h000);
      cpu_wr = 1'b1;
      wait_cpu_ack("post_rst_cpu_ack");
      cpu_wr = 1'b0;
      repeat (3) tick();

      chk("sb_mem_drained", exp_mem.size(), 0);
      chk("sb_vid_drained", exp_vid.size(), 0);
      chk("sb_cpu_drained", exp_cpu.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
